md_wb_ctrl: RTL
===============

Name: md_wb_ctrl

Overview:
- Sequences the multicycle mult/div unit for a pipelined 32-bit core.
- Accepts mult/div instructions from the DX stage and launches the multdiv unit.
- Tracks the in-flight destination register and raises pipeline stalls for structural conflicts and RAW hazards.
- Shares the single register-file write port between the MW-stage writeback path (priority) and the completing mult/div result, including exception writes to the status register.

Parameters:
- STATUS_REG, 30, register written on mult/div exception
- MULT_EXC_CODE, 4, value written to STATUS_REG on mult exception
- DIV_EXC_CODE, 5, value written to STATUS_REG on div exception
- MAX_CYCLES, 40, cycles in RUN without md_resultRDY before forced timeout exception

Ports:
- clock in 1: single clock, rising edge.
- reset in 1: asynchronous, active-high.
- issue_valid in 1: DX-stage mult/div instruction present.
- issue_isMult in 1, issue_isDiv in 1: operation select.
- issue_rd in 5: destination register.
- issue_a in 32, issue_b in 32: operands.
- fd_rs1 in 5, fd_rs2 in 5: source registers of the instruction in decode.
- md_ctrl_MULT out 1, md_ctrl_DIV out 1: one-cycle start pulses to multdiv.
- md_a out 32, md_b out 32: latched operands to multdiv.
- md_result in 32, md_exception in 1, md_resultRDY in 1: multdiv completion.
- wb_we_pipe in 1, wb_reg_pipe in 5, wb_data_pipe in 32: MW-stage writeback request.
- rf_we out 1, rf_reg out 5, rf_data out 32: register-file write port.
- stall out 1: freezes PC/FD/DX.
- busy out 1: state != IDLE.

Behaviour:
- Reset: state=IDLE; cnt, latched rd/op/operands/result all 0. md_ctrl_* are cleared asynchronously. rf_* follow the combinational mux, so with wb_we_pipe=0 all rf_* are 0.
- States: IDLE, RUN, WB.
- IDLE accepts an issue when issue_valid and exactly one of isMult/isDiv is set:
  - latch rd, op, issue_a/b into md_a/md_b; clear cnt; go to RUN.
  - the matching md_ctrl_* is high for exactly the following cycle (registered).
  - issue_valid with both or neither op bit set is ignored: no state change, no stall.
- RUN:
  - cnt increments each cycle.
  - On md_resultRDY: capture md_result and md_exception; go to WB.
  - If cnt reaches MAX_CYCLES-1 without ready: set exception=1, go to WB.
  - md_a/md_b stay stable throughout RUN.
- WB, write target:
  - exception=1 writes STATUS_REG with MULT_EXC_CODE or DIV_EXC_CODE per the latched op.
  - exception=0 writes the latched rd with the captured result.
  - With no exception and rd=0, no write occurs and the next state is IDLE.
- WB, port sharing:
  - If wb_we_pipe=0: drive the write for exactly one cycle, then go to IDLE.
  - If wb_we_pipe=1: the pipeline wins and WB holds (no cycle limit).
- Port mux (combinational):
  - wb_we_pipe=1: rf_* = pipe signals.
  - else WB with a write due: rf_we=1 with controller reg/data.
  - else: rf_we=0, rf_reg=0, rf_data=0.
- stall (combinational) is 1 when any of:
  - state!=IDLE and issue_valid with a legal op (second mult/div);
  - state!=IDLE and latched rd!=0 and (fd_rs1==rd or fd_rs2==rd);
  - state!=IDLE and exception path active and either fd_rs equals STATUS_REG.
- Issue arriving in the same cycle WB retires is stalled; it is accepted next cycle from IDLE.
- md_resultRDY outside RUN is ignored.
- Reset mid-RUN/WB: pending write is dropped; no rf_we.

Test Plan:
- Mult 6*7, rd=5, ready after 32 cycles, pipe idle -> md_ctrl_MULT single pulse at cycle 1; rf_we=1, rf_reg=5, rf_data=42 one cycle after ready; busy falls next cycle.
- Same, but wb_we_pipe=1 (reg 9, data 0x11) for 3 cycles at completion -> rf_* carry pipe writes for those 3 cycles; mult write of 42 to r5 occurs on cycle 4; no lost write.
- Div 10/0 with md_exception=1 -> rf_reg=30, rf_data=5. Mult overflow -> rf_data=4.
- Second legal issue and fd_rs1=5 while rd=5 in flight -> stall=1 until IDLE; then issue accepted and stall drops. fd_rs1=0 with rd=0 -> no stall.
- md_resultRDY never asserted -> at cnt=39, write r30=MULT_EXC_CODE/DIV_EXC_CODE per op; md_resultRDY asserted afterwards while IDLE -> ignored.
- Reset asserted mid-RUN -> busy=0, md_ctrl_*=0, rf_we=0 immediately; no late write after reset release.

Source files
------------

// File: rtl/md_wb_ctrl_if.sv
// Bundles the issue, multdiv, writeback and register-file signals of the
// mult/div sequencer. The controller takes the slave view, the driver the master view.
interface md_wb_ctrl_if;
  logic        issue_valid;
  logic        issue_isMult;
  logic        issue_isDiv;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  fd_rs1;
  logic [4:0]  fd_rs2;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_we_pipe;
  logic [4:0]  wb_reg_pipe;
  logic [31:0] wb_data_pipe;
  logic        rf_we;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data;
  logic        stall;
  logic        busy;

  modport slave (
    input  issue_valid, issue_isMult, issue_isDiv, issue_rd, issue_a, issue_b,
    input  fd_rs1, fd_rs2,
    input  md_result, md_exception, md_resultRDY,
    input  wb_we_pipe, wb_reg_pipe, wb_data_pipe,
    output md_ctrl_MULT, md_ctrl_DIV, md_a, md_b,
    output rf_we, rf_reg, rf_data, stall, busy
  );

  modport master (
    output issue_valid, issue_isMult, issue_isDiv, issue_rd, issue_a, issue_b,
    output fd_rs1, fd_rs2,
    output md_result, md_exception, md_resultRDY,
    output wb_we_pipe, wb_reg_pipe, wb_data_pipe,
    input  md_ctrl_MULT, md_ctrl_DIV, md_a, md_b,
    input  rf_we, rf_reg, rf_data, stall, busy
  );
endinterface

// File: rtl/md_wb_ctrl.sv
// Mult/div sequencer: launches the multdiv unit, tracks the in-flight
// destination for hazard stalls and shares the register-file write port
// with the MW-stage writeback path (which always has priority).
//
// state | meaning
// IDLE  | no mult/div in flight, accepting a legal issue
// RUN   | multdiv busy, counting cycles until ready or timeout
// WB    | result (or exception code) waiting for the write port
module md_wb_ctrl #(
  parameter int STATUS_REG    = 30,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5,
  parameter int MAX_CYCLES    = 40
) (
  input logic         clock,
  input logic         reset,
  md_wb_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam int CW = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [4:0] ST_REG = 5'(STATUS_REG);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [4:0]    rd_q;
  logic          op_mult;
  logic [31:0]   res_q;
  logic          exc_q;

  logic        legal_issue;
  logic        accept;
  logic        write_due;
  logic [31:0] exc_code;
  logic        rd_hazard;
  logic        st_hazard;

  assign legal_issue = bus.issue_valid & (bus.issue_isMult ^ bus.issue_isDiv);
  assign accept      = (state == S_IDLE) & legal_issue;
  // A clean result targeting r0 is simply dropped.
  assign write_due   = exc_q | (rd_q != 5'd0);
  assign exc_code    = op_mult ? 32'(MULT_EXC_CODE) : 32'(DIV_EXC_CODE);
  assign bus.busy    = (state != S_IDLE);

  assign rd_hazard = (rd_q != 5'd0) & ((bus.fd_rs1 == rd_q) | (bus.fd_rs2 == rd_q));
  // exc_q is cleared on issue, so it is only set once the exception is pending in WB.
  assign st_hazard = exc_q & ((bus.fd_rs1 == ST_REG) | (bus.fd_rs2 == ST_REG));
  assign bus.stall = bus.busy & (legal_issue | rd_hazard | st_hazard);

  // Sequencer state, operand/result latches and registered start pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      rd_q             <= 5'd0;
      op_mult          <= 1'b0;
      res_q            <= 32'd0;
      exc_q            <= 1'b0;
      bus.md_a         <= 32'd0;
      bus.md_b         <= 32'd0;
      bus.md_ctrl_MULT <= 1'b0;
      bus.md_ctrl_DIV  <= 1'b0;
    end else begin
      bus.md_ctrl_MULT <= accept & bus.issue_isMult;
      bus.md_ctrl_DIV  <= accept & bus.issue_isDiv;
      case (state)
        S_IDLE: begin
          if (accept) begin
            rd_q     <= bus.issue_rd;
            op_mult  <= bus.issue_isMult;
            bus.md_a <= bus.issue_a;
            bus.md_b <= bus.issue_b;
            cnt      <= '0;
            res_q    <= 32'd0;
            exc_q    <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (bus.md_resultRDY) begin
            res_q <= bus.md_result;
            exc_q <= bus.md_exception;
            state <= S_WB;
          end else if (cnt == CNT_LAST) begin
            exc_q <= 1'b1;
            state <= S_WB;
          end
        end
        S_WB: begin
          // Hold only while the pipeline owns the port and we still have a write.
          if (!write_due || !bus.wb_we_pipe) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register-file write port: pipeline first, then the pending mult/div write.
  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_reg  = 5'd0;
    bus.rf_data = 32'd0;
    if (bus.wb_we_pipe) begin
      bus.rf_we   = 1'b1;
      bus.rf_reg  = bus.wb_reg_pipe;
      bus.rf_data = bus.wb_data_pipe;
    end else if (state == S_WB && write_due) begin
      bus.rf_we   = 1'b1;
      bus.rf_reg  = exc_q ? ST_REG : rd_q;
      bus.rf_data = exc_q ? exc_code : res_q;
    end
  end

endmodule
